// File: rtl/key_calc_ctrl.sv
// Two-key operand entry and calculate controller for an external 4-bit adder.
// Keys are synchronized and debounced; the FSM acts on debounced falling edges.
module key_calc_ctrl #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       show,
  input  logic       calc,
  input  logic [3:0] segdata,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] disp_hi,
  output logic [3:0] disp_lo,
  output logic [1:0] state,
  output logic       result_valid
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    GOT_B = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t          st;
  logic [1:0]      keys;
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      lvl;
  logic [1:0]      fall;
  logic [CW-1:0]   cnt [2];
  logic [3:0]      res_s;
  logic            res_c;

  // index 0 is show, index 1 is calc
  assign keys = {calc, show};

  always_comb begin
    fall = '0;
    for (int i = 0; i < 2; i++) begin
      fall[i] = lvl[i] & ~s2[i] & (cnt[i] == CMAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '1;
      s2     <= '1;
      lvl    <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          lvl[i] <= ~lvl[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res_s <= '0;
      res_c <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (fall[0]) begin
            op_a <= segdata;
            op_b <= '0;
            st   <= GOT_A;
          end
        end
        GOT_A: begin
          if (fall[0]) begin
            op_b <= segdata;
            st   <= GOT_B;
          end
        end
        GOT_B: begin
          // a simultaneous show press swallows the calc press
          if (fall[1] && !fall[0]) begin
            res_s <= sum_in;
            res_c <= cout_in;
            st    <= DONE;
          end
        end
        DONE: begin
          if (fall[0]) begin
            op_a <= segdata;
            op_b <= '0;
            st   <= GOT_A;
          end
        end
      endcase
    end
  end

  assign state        = st;
  assign result_valid = (st == DONE);

  always_comb begin
    disp_hi = '0;
    disp_lo = '0;
    unique case (st)
      IDLE: begin
        disp_hi = '0;
        disp_lo = '0;
      end
      GOT_A: begin
        disp_hi = op_a;
        disp_lo = '0;
      end
      GOT_B: begin
        disp_hi = op_a;
        disp_lo = op_b;
      end
      DONE: begin
        disp_hi = {3'b000, res_c};
        disp_lo = res_s;
      end
    endcase
  end

endmodule

// File: tb/tb_key_calc_ctrl.sv
// Bench for key_calc_ctrl: windowed debounce model plus operand FSM model,
// checked every cycle, with directed scenarios pinned by literal values.
module tb_key_calc_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       show = 1'b1;
  logic       calc = 1'b1;
  logic [3:0] segdata = '0;
  logic [3:0] sum_in;
  logic       cout_in;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] disp_hi;
  logic [3:0] disp_lo;
  logic [1:0] state;
  logic       result_valid;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  // ideal external adder
  assign {cout_in, sum_in} = {1'b0, op_a} + {1'b0, op_b};

  key_calc_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .show(show),
    .calc(calc),
    .segdata(segdata),
    .sum_in(sum_in),
    .cout_in(cout_in),
    .op_a(op_a),
    .op_b(op_b),
    .disp_hi(disp_hi),
    .disp_lo(disp_lo),
    .state(state),
    .result_valid(result_valid)
  );

  // model: raw samples per key, oldest first; a level flips when
  // the DEB samples seen by the debouncer all differ from it
  bit       hist [2][DEB+2];
  bit       lvl  [2];
  int       ms = 0;
  bit [3:0] ma, mb, mrs;
  bit       mrc;

  task automatic model_step();
    bit raw [2];
    bit fall [2];
    bit all;
    logic [4:0] s5;
    raw[0] = show;
    raw[1] = calc;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < DEB + 2; j++) hist[k][j] = 1'b1;
        lvl[k] = 1'b1;
      end
      ms = 0; ma = 0; mb = 0; mrs = 0; mrc = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < DEB + 1; j++) hist[k][j] = hist[k][j+1];
        hist[k][DEB+1] = raw[k];
        all = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (hist[k][j] == lvl[k]) all = 1'b0;
        fall[k] = 1'b0;
        if (all) begin
          fall[k] = lvl[k];
          lvl[k]  = ~lvl[k];
        end
      end
      case (ms)
        0: if (fall[0]) begin ma = segdata; mb = 0; ms = 1; end
        1: if (fall[0]) begin mb = segdata; ms = 2; end
        2: if (fall[1] && !fall[0]) begin
             s5  = {1'b0, ma} + {1'b0, mb};
             mrc = s5[4];
             mrs = s5[3:0];
             ms  = 3;
           end
        default: if (fall[0]) begin ma = segdata; mb = 0; ms = 1; end
      endcase
    end
  endtask

  function automatic logic [18:0] expv();
    logic [3:0] dh, dl;
    logic [1:0] s;
    s = 2'(ms);
    case (s)
      2'd0: begin dh = 0; dl = 0; end
      2'd1: begin dh = ma; dl = 0; end
      2'd2: begin dh = ma; dl = mb; end
      default: begin dh = {3'b000, mrc}; dl = mrs; end
    endcase
    return {s, ma, mb, dh, dl, (s == 2'd3)};
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      n_tests++;
      if ({state, op_a, op_b, disp_hi, disp_lo, result_valid} !== expv()) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time,
          {state, op_a, op_b, disp_hi, disp_lo, result_valid}, expv());
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input bit r, input bit sh, input bit ca,
                      input logic [3:0] sd);
    rst = r; show = sh; calc = ca; segdata = sd;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic press(input bit which, input logic [3:0] sd,
                       input int hold);
    for (int i = 0; i < hold; i++) tick(1'b0, which, !which, sd);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1, sd);
  endtask

  initial begin
    bit rs, rc;
    int ls, lc;
    tick(1, 1, 1, 0);
    tick(1, 1, 1, 0);
    chk_on = 1'b1;
    chk("reset_outputs",
        {state, op_a, op_b, disp_hi, disp_lo, result_valid}, 0);

    // operand 3 then 9, calculate
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1, 4'h3);
      if (i == 4) chk("s1_edge4_idle", state, 2'b00);
      if (i == 5) chk("s1_edge5_op_a", {state, op_a}, {2'b01, 4'h3});
    end
    for (int i = 0; i < 10; i++) tick(0, 1, 1, 4'h3);
    press(0, 4'h9, 10);
    chk("s1_got_b", {state, op_a, op_b}, {2'b10, 4'h3, 4'h9});
    press(1, 4'h9, 10);
    chk("s1_done", {state, disp_hi, disp_lo, result_valid},
        {2'b11, 4'h0, 4'hC, 1'b1});

    // new calculation from DONE
    press(0, 4'h7, 10);
    chk("done_show",
        {state, op_a, op_b, disp_hi, disp_lo, result_valid},
        {2'b01, 4'h7, 4'h0, 4'h7, 4'h0, 1'b0});

    // F + F carries out
    tick(1, 1, 1, 0);
    press(0, 4'hF, 10);
    press(0, 4'hF, 10);
    press(1, 4'hF, 10);
    chk("ff_carry", {state, disp_hi, disp_lo}, {2'b11, 4'h1, 4'hE});

    // short glitches, then one valid press
    tick(1, 1, 1, 0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 4'h5);
      tick(0, 1, 1, 4'h5);
    end
    chk("glitch_idle", {state, op_a}, {2'b00, 4'h0});
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 4'h5);
    for (int i = 0; i < 10; i++) tick(0, 1, 1, 4'h5);
    chk("hold4_one_step", {state, op_a, op_b}, {2'b01, 4'h5, 4'h0});

    // calc ignored; simultaneous show+calc in GOT_A
    tick(1, 1, 1, 0);
    press(1, 4'h5, 10);
    chk("calc_idle", {state, op_a, op_b}, 0);
    press(0, 4'h5, 10);
    press(1, 4'h6, 10);
    chk("calc_got_a", {state, op_a, op_b}, {2'b01, 4'h5, 4'h0});
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 4'h6);
    for (int i = 0; i < 10; i++) tick(0, 1, 1, 4'h6);
    chk("both_got_a", {state, op_b, disp_lo, result_valid},
        {2'b10, 4'h6, 4'h6, 1'b0});

    // reset in GOT_B with show held low
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 4'h8);
    tick(1, 0, 1, 4'h8);
    chk("rst_got_b",
        {state, op_a, op_b, disp_hi, disp_lo, result_valid}, 0);
    for (int i = 1; i <= 6; i++) begin
      tick(0, 0, 1, 4'h8);
      if (i == 5) chk("rst_hold_wait", state, 2'b00);
      if (i == 6) chk("rst_hold_act", {state, op_a}, {2'b01, 4'h8});
    end
    for (int i = 0; i < 10; i++) tick(0, 1, 1, 4'h8);

    // randomized key activity with occasional reset
    rs = 1; rc = 1;
    ls = $urandom_range(1, 12);
    lc = $urandom_range(1, 12);
    for (int n = 0; n < 3000; n++) begin
      ls--;
      lc--;
      if (ls == 0) begin rs = !rs; ls = $urandom_range(1, 12); end
      if (lc == 0) begin rc = !rc; lc = $urandom_range(1, 12); end
      tick($urandom_range(0, 249) == 0, rs, rc, 4'($urandom));
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
